// File: rtl/read_master_port.sv
// Per-master read front end: allocates a transaction slot for each AR request,
// forwards the request to the arbiter and interconnect, and returns R beats through a 2-entry skid buffer.
module read_master_port #(
    parameter int M                     = 2,
    parameter int NUM_OUTSTANDING_TRANS = 2,
    parameter int MASTER_ID             = 0,
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    localparam int MID_W = $clog2(M),
    localparam int TID_W = $clog2(NUM_OUTSTANDING_TRANS),
    localparam int ID_W  = MID_W + TID_W,
    localparam int CNT_W = $clog2(NUM_OUTSTANDING_TRANS + 1)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    output logic                  AR_request,
    output logic [ADDR_WIDTH-1:0] AR_addr,
    output logic [TID_W-1:0]      AR_id,
    input  logic                  AR_grant,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [ID_W-1:0]       m_arid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [ID_W-1:0]       m_rid,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  rid_err
);

    localparam int N     = NUM_OUTSTANDING_TRANS;
    localparam int BUF_W = DATA_WIDTH + 2 + 1 + ID_W;
    localparam logic [MID_W-1:0] MID = MID_W'(MASTER_ID);

    typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;

    ar_state_t             ar_state, ar_state_nxt;
    logic                  run;
    logic [N-1:0]          busy, busy_nxt;
    logic [TID_W-1:0]      free_slot;
    logic                  any_free;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [ID_W-1:0]       arid_q;
    logic                  ar_accept;

    logic [BUF_W-1:0]      buf_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count, count_nxt;
    logic                  r_push, r_pop;
    logic [BUF_W-1:0]      head;
    logic [ID_W-1:0]       head_rid;
    logic                  rid_bad;

    // Every channel transfers on a cycle where valid and ready are both high;
    // valid never waits on ready, and payload is held while valid is high.

    always_comb begin
        free_slot = '0;
        any_free  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_slot = TID_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N; i++) begin
            outstanding = outstanding + CNT_W'(busy[i]);
        end
    end

    always_comb begin
        ar_state_nxt = ar_state;
        s_arready    = 1'b0;
        AR_request   = 1'b0;
        m_arvalid    = 1'b0;
        case (ar_state)
            AR_IDLE: begin
                s_arready = run && any_free;
                if (s_arvalid && s_arready) ar_state_nxt = AR_REQ;
            end
            AR_REQ: begin
                AR_request = 1'b1;
                m_arvalid  = AR_grant;
                if (m_arvalid && m_arready) ar_state_nxt = AR_IDLE;
            end
        endcase
    end

    assign ar_accept = s_arvalid && s_arready;
    assign AR_addr   = addr_q;
    assign AR_id     = arid_q[TID_W-1:0];
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arid    = arid_q;

    assign r_push    = m_rvalid && m_rready;
    assign r_pop     = s_rvalid && s_rready;
    assign s_rvalid  = (count != 2'd0);
    assign head      = buf_mem[rd_ptr];
    assign {s_rdata, s_rresp, s_rlast, head_rid} = head;
    assign count_nxt = count + 2'(r_push) - 2'(r_pop);
    assign rid_bad   = (m_rid[ID_W-1:TID_W] != MID) || !busy[m_rid[TID_W-1:0]];

    // Free on the delivered last beat and allocate on accept; they never hit the same slot.
    always_comb begin
        busy_nxt = busy;
        if (r_pop && s_rlast) busy_nxt[head_rid[TID_W-1:0]] = 1'b0;
        if (ar_accept) busy_nxt[free_slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ar_state <= AR_IDLE;
            run      <= 1'b0;
            busy     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            arid_q   <= '0;
        end else begin
            ar_state <= ar_state_nxt;
            run      <= 1'b1;
            busy     <= busy_nxt;
            if (ar_accept) begin
                addr_q <= s_araddr;
                len_q  <= s_arlen;
                arid_q <= {MID, free_slot};
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            m_rready   <= 1'b0;
            rid_err    <= 1'b0;
        end else begin
            if (r_push) begin
                buf_mem[wr_ptr] <= {m_rdata, m_rresp, m_rlast, m_rid};
                wr_ptr          <= ~wr_ptr;
            end
            if (r_pop) rd_ptr <= ~rd_ptr;
            count    <= count_nxt;
            m_rready <= (count_nxt != 2'd2);
            if (r_push && rid_bad) rid_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_read_master_port.sv
// Bench for read_master_port: a transaction-level model (slot set, pending request,
// expected beat queue) is checked every cycle under directed tables and random traffic.
module tb_read_master_port;

    localparam int M = 2, NT = 2, MASTER_ID = 1, AW = 32, DW = 32;
    localparam int MID_W = 1, TID_W = 1, IDW = 2, CNT_W = 2;
    localparam int BEAT_W = DW + 2 + 1 + IDW;
    localparam int LAST_B = IDW, RESP_LO = IDW + 1, DATA_LO = IDW + 3;
    localparam logic [MID_W-1:0] MID = 1'b1;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic s_arvalid, s_arready, AR_request, AR_grant, m_arvalid, m_arready;
    logic [AW-1:0] s_araddr, AR_addr, m_araddr;
    logic [7:0] s_arlen, m_arlen;
    logic [TID_W-1:0] AR_id;
    logic [IDW-1:0] m_arid, m_rid;
    logic m_rvalid, m_rready, m_rlast, s_rvalid, s_rready, s_rlast, rid_err;
    logic [DW-1:0] m_rdata, s_rdata;
    logic [1:0] m_rresp, s_rresp;
    logic [CNT_W-1:0] outstanding;

    read_master_port #(.M(M), .NUM_OUTSTANDING_TRANS(NT), .MASTER_ID(MASTER_ID),
                       .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .clr(clr),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .AR_request(AR_request), .AR_addr(AR_addr), .AR_id(AR_id), .AR_grant(AR_grant),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .outstanding(outstanding), .rid_err(rid_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [TID_W-1:0] slot;
        int               len;
    } tr_t;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        int             gdly;
        int             rdly;
        logic [IDW-1:0] exp_id;
        logic [NT-1:0]  free_mask;
        int             exp_out;
    } ar_vec_t;

    logic [BEAT_W-1:0] exp_q[$];
    tr_t               issued_q[$];
    bit                busy_m [NT];
    bit                pend, err_m;
    logic [AW-1:0]     pend_addr;
    logic [7:0]        pend_len;
    logic [TID_W-1:0]  pend_slot;
    bit                ev_acc, ev_hs, ev_push, ev_pop;
    int                n_popped = 0;
    int                n_hs = 0;
    int                beat_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive_idle();
        s_arvalid = 0; s_araddr = '0; s_arlen = '0;
        AR_grant = 0; m_arready = 0;
        m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
        s_rready = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) busy_m[i] = 0;
        pend = 0; err_m = 0;
        exp_q.delete(); issued_q.delete();
        beat_idx = 0;
        ev_acc = 0; ev_hs = 0; ev_push = 0; ev_pop = 0;
    endtask

    task automatic chk_reset();
        chk("rst_s_arready", s_arready, 0);
        chk("rst_AR_request", AR_request, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_s_rlast", s_rlast, 0);
        chk("rst_rid_err", rid_err, 0);
        chk("rst_AR_addr", AR_addr, 0);
        chk("rst_AR_id", AR_id, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_m_arid", m_arid, 0);
        chk("rst_s_rdata", s_rdata, 0);
        chk("rst_s_rresp", s_rresp, 0);
        chk("rst_outstanding", outstanding, 0);
    endtask

    // Called at posedge+1; asserts clr immediately, leaves at posedge+1 one edge after release.
    task automatic apply_reset();
        clr = 0;
        #1;
        chk_reset();
        model_reset();
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        clr = 1;
        @(posedge clk);
        #1;
        chk("rst_m_rready_after", m_rready, 1);
    endtask

    // One clock: compare DUT to the model, then advance the model by the rules.
    task automatic cycle();
        logic [BEAT_W-1:0] head;
        int nfree, slot;
        #1;
        nfree = 0; slot = 0;
        for (int i = NT - 1; i >= 0; i--) if (!busy_m[i]) begin nfree++; slot = i; end
        chk("s_arready", s_arready, !pend && nfree > 0);
        chk("AR_request", AR_request, pend);
        chk("m_arvalid", m_arvalid, pend && AR_grant);
        if (pend) begin
            chk("AR_addr", AR_addr, pend_addr);
            chk("AR_id", AR_id, pend_slot);
            chk("m_araddr", m_araddr, pend_addr);
            chk("m_arlen", m_arlen, pend_len);
            chk("m_arid", m_arid, {MID, pend_slot});
        end
        chk("m_rready", m_rready, exp_q.size() < 2);
        chk("s_rvalid", s_rvalid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk("s_rdata", s_rdata, head[DATA_LO +: DW]);
            chk("s_rresp", s_rresp, head[RESP_LO +: 2]);
            chk("s_rlast", s_rlast, head[LAST_B]);
        end
        chk("outstanding", outstanding, NT - nfree);
        chk("rid_err", rid_err, err_m);

        ev_acc  = s_arvalid && !pend && nfree > 0;
        ev_hs   = pend && AR_grant && m_arready;
        ev_push = m_rvalid && exp_q.size() < 2;
        ev_pop  = s_rready && exp_q.size() > 0;

        if (ev_push && (m_rid[IDW-1:TID_W] != MID || !busy_m[m_rid[TID_W-1:0]])) err_m = 1;
        if (ev_pop) begin
            head = exp_q.pop_front();
            if (head[LAST_B]) busy_m[head[TID_W-1:0]] = 0;
            n_popped++;
        end
        if (ev_push) exp_q.push_back({m_rdata, m_rresp, m_rlast, m_rid});
        if (ev_acc) begin
            busy_m[slot] = 1;
            pend = 1;
            pend_slot = TID_W'(slot);
            pend_addr = s_araddr;
            pend_len = s_arlen;
        end
        if (ev_hs) begin
            pend = 0;
            issued_q.push_back('{slot: pend_slot, len: int'(pend_len)});
            n_hs++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic accept_ar(input logic [AW-1:0] addr, input logic [7:0] len);
        bit got = 0;
        s_arvalid = 1; s_araddr = addr; s_arlen = len;
        for (int k = 0; k < 50 && !got; k++) begin
            cycle();
            got = ev_acc;
        end
        s_arvalid = 0;
        chk("ar_accept_timeout", got, 1);
    endtask

    task automatic finish_ar();
        bit got = 0;
        AR_grant = 1; m_arready = 1;
        for (int k = 0; k < 50 && !got; k++) begin
            cycle();
            got = ev_hs;
        end
        AR_grant = 0; m_arready = 0;
        chk("ar_hs_timeout", got, 1);
    endtask

    task automatic rel_slot(input logic [TID_W-1:0] s);
        bit got = 0;
        m_rvalid = 1; m_rid = {MID, s}; m_rlast = 1;
        m_rdata = $urandom; m_rresp = 2'($urandom_range(0, 3));
        s_rready = 1;
        for (int k = 0; k < 50 && !got; k++) begin
            cycle();
            got = ev_push;
        end
        m_rvalid = 0; m_rlast = 0;
        chk("rel_push_timeout", got, 1);
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) cycle();
        chk("rel_drain", exp_q.size(), 0);
    endtask

    task automatic gen_r(input int pct);
        if (m_rvalid && !ev_push) return;
        if (issued_q.size() > 0 && $urandom_range(0, 99) < pct) begin
            m_rvalid = 1;
            m_rid    = {MID, issued_q[0].slot};
            m_rlast  = (beat_idx == issued_q[0].len);
            m_rdata  = $urandom;
            m_rresp  = 2'($urandom_range(0, 3));
        end else begin
            m_rvalid = 0;
        end
    endtask

    task automatic adv_r();
        if (ev_push) begin
            if (m_rlast) begin
                void'(issued_q.pop_front());
                beat_idx = 0;
            end else begin
                beat_idx++;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    ar_vec_t vecs[5];

    initial begin
        logic [3:0] pat;
        logic [DW-1:0] d;
        bit saw_stall, done;
        int b, p0, out0;

        vecs[0] = '{addr: 32'h0001_0040, len: 8'd3,   gdly: 2, rdly: 0, exp_id: 2'b10, free_mask: 2'b00, exp_out: 1};
        vecs[1] = '{addr: 32'h0000_1000, len: 8'd0,   gdly: 0, rdly: 1, exp_id: 2'b11, free_mask: 2'b01, exp_out: 1};
        vecs[2] = '{addr: 32'hFFFF_FFFC, len: 8'd255, gdly: 5, rdly: 3, exp_id: 2'b10, free_mask: 2'b11, exp_out: 0};
        vecs[3] = '{addr: 32'h8000_0000, len: 8'd7,   gdly: 1, rdly: 0, exp_id: 2'b10, free_mask: 2'b00, exp_out: 1};
        vecs[4] = '{addr: 32'h1234_5678, len: 8'd1,   gdly: 0, rdly: 0, exp_id: 2'b11, free_mask: 2'b11, exp_out: 0};

        drive_idle();
        apply_reset();

        // AR table: grant delay, interconnect backpressure, slot allocation
        foreach (vecs[i]) begin
            accept_ar(vecs[i].addr, vecs[i].len);
            repeat (vecs[i].gdly) cycle();
            AR_grant = 1; m_arready = 0;
            repeat (vecs[i].rdly) cycle();
            chk("tbl_m_arid", m_arid, vecs[i].exp_id);
            chk("tbl_m_araddr", m_araddr, vecs[i].addr);
            m_arready = 1;
            p0 = n_hs;
            cycle();
            AR_grant = 0; m_arready = 0;
            chk("tbl_one_hs", n_hs - p0, 1);
            chk("tbl_req_drop", AR_request, 0);
            for (int s = 0; s < NT; s++) if (vecs[i].free_mask[s]) rel_slot(TID_W'(s));
            chk("tbl_outstanding", outstanding, vecs[i].exp_out);
        end

        // Pool exhaustion: third request waits for the first last beat
        accept_ar($urandom, 8'd0); finish_ar();
        accept_ar($urandom, 8'd0); finish_ar();
        s_arvalid = 1; s_araddr = 32'hCAFE_0000; s_arlen = 8'd2;
        repeat (4) cycle();
        chk("pool_full_arready", s_arready, 0);
        rel_slot(1'b0);
        s_arvalid = 1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin cycle(); done = ev_acc; end
        s_arvalid = 0;
        chk("pool_third_accept", done, 1);
        chk("pool_third_slot", AR_id, 0);
        finish_ar();
        rel_slot(1'b0);
        rel_slot(1'b1);

        // R backpressure: 8 beats, s_rready pattern 1,0,0,1
        accept_ar(32'h0000_2000, 8'd7); finish_ar();
        pat = 4'b1001; saw_stall = 0; b = 0; p0 = n_popped;
        for (int c = 0; c < 64 && b < 8; c++) begin
            m_rvalid = 1; m_rid = {MID, 1'b0}; m_rdata = 32'hA000_0000 + b;
            m_rresp = 2'(b); m_rlast = (b == 7);
            s_rready = pat[c % 4];
            cycle();
            if (!m_rready) saw_stall = 1;
            if (ev_push) b++;
        end
        m_rvalid = 0; m_rlast = 0; s_rready = 1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
        chk("bp_beats", n_popped - p0, 8);
        chk("bp_stall_seen", saw_stall, 1);
        chk("bp_outstanding", outstanding, 0);

        // Randomized traffic against the model
        issued_q.delete(); beat_idx = 0;
        for (int c = 0; c < 3000; c++) begin
            if (ev_acc || !s_arvalid) begin
                s_arvalid = ($urandom_range(0, 3) == 0);
                s_araddr  = $urandom;
                s_arlen   = 8'($urandom_range(0, 3));
            end
            AR_grant  = ($urandom_range(0, 2) != 0);
            m_arready = ($urandom_range(0, 2) != 0);
            s_rready  = ($urandom_range(0, 3) != 0);
            gen_r(70);
            cycle();
            adv_r();
        end
        s_arvalid = 0; AR_grant = 1; m_arready = 1; s_rready = 1;
        done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            gen_r(100);
            if (!pend && issued_q.size() == 0 && exp_q.size() == 0 && !m_rvalid) done = 1;
            else begin cycle(); adv_r(); end
        end
        AR_grant = 0; m_arready = 0;
        chk("rand_drain", done, 1);
        chk("rand_outstanding", outstanding, 0);

        // Error: beat to a free slot is flagged but forwarded
        d = 32'h5EED_0001;
        m_rvalid = 1; m_rid = {MID, 1'b1}; m_rlast = 0; m_rdata = d; m_rresp = 2'b10; s_rready = 0;
        cycle();
        m_rvalid = 0;
        chk("err_free_slot", rid_err, 1);
        chk("err_free_fwd", s_rdata, d);
        s_rready = 1; cycle();
        apply_reset();

        // Error: wrong master ID with rlast leaves busy untouched
        accept_ar(32'h0000_3000, 8'd3); finish_ar();
        d = 32'h5EED_0002;
        m_rvalid = 1; m_rid = 2'b01; m_rlast = 1; m_rdata = d; m_rresp = 2'b00; s_rready = 0;
        cycle();
        m_rvalid = 0; m_rlast = 0;
        chk("err_master", rid_err, 1);
        chk("err_master_fwd", s_rdata, d);
        out0 = outstanding;
        s_rready = 1; cycle(); s_rready = 0;
        chk("err_busy_kept", outstanding, 1);
        chk("err_busy_same", outstanding, out0);

        // Mid-burst reset
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1; m_rid = {MID, 1'b0}; m_rdata = $urandom; m_rlast = 0;
            cycle();
        end
        m_rvalid = 0;
        accept_ar(32'h0000_4000, 8'd1);
        AR_grant = 1;
        apply_reset();
        accept_ar(32'h0000_5000, 8'd0);
        chk("rst_new_slot", AR_id, 0);
        finish_ar();
        rel_slot(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/read_master_port.md
# read_master_port

Master-side front end of the read path, one instance per master, directly upstream of the read arbiter. It accepts AXI read-address requests from its master and allocates a transaction ID from a free pool of `NUM_OUTSTANDING_TRANS` slots. It requests and waits for an arbiter grant, then hands the address to the interconnect AR bus. It also returns routed R beats to the master through a 2-entry skid buffer, freeing the ID slot on the last beat.

## Interface
- `M`, 2, number of masters; `MID_W = $clog2(M)`
- `NUM_OUTSTANDING_TRANS`, 2, ID slots per master; `TID_W = $clog2(NUM_OUTSTANDING_TRANS)`
- `MASTER_ID`, 0, this port's master index, placed in the upper ID field
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, read data width

Ports (name, direction, width, meaning):
- `clk`, in, 1, clock
- `clr`, in, 1, reset; asynchronous, active-low
- `s_arvalid`, in, 1, master AR valid
- `s_arready`, out, 1, master AR ready
- `s_araddr`, in, ADDR_WIDTH, master AR address
- `s_arlen`, in, 8, master AR burst length
- `AR_request`, out, 1, request to the arbiter
- `AR_addr`, out, ADDR_WIDTH, captured address, sent to the arbiter's decoder
- `AR_id`, out, TID_W, allocated slot
- `AR_grant`, in, 1, grant from the arbiter
- `m_arvalid`, out, 1, interconnect AR valid
- `m_arready`, in, 1, interconnect AR ready
- `m_araddr`, out, ADDR_WIDTH, interconnect AR address
- `m_arlen`, out, 8, interconnect AR burst length
- `m_arid`, out, MID_W+TID_W, `{MASTER_ID, slot}`
- `m_rvalid`, in, 1, routed R beat valid
- `m_rready`, out, 1, routed R beat ready
- `m_rdata`, in, DATA_WIDTH, routed R data
- `m_rresp`, in, 2, routed R response
- `m_rlast`, in, 1, routed R last
- `m_rid`, in, MID_W+TID_W, routed R ID
- `s_rvalid`, out, 1, master R valid
- `s_rready`, in, 1, master R ready
- `s_rdata`, out, DATA_WIDTH, master R data
- `s_rresp`, out, 2, master R response
- `s_rlast`, out, 1, master R last
- `outstanding`, out, $clog2(NUM_OUTSTANDING_TRANS+1), number of busy slots
- `rid_err`, out, 1, sticky flag for an R-ID error

## Operation
- **Slot pool:** registered `busy[NUM_OUTSTANDING_TRANS-1:0]`. Allocation takes the lowest-index clear bit. `outstanding` is the popcount of `busy`.
- **AR FSM** (registered state):
  - IDLE:
    - `s_arready = |~busy`.
    - On `s_arvalid && s_arready`: capture `s_araddr` and `s_arlen`, record the slot, set `busy[slot]`, go to REQ.
  - REQ:
    - `AR_request = 1`.
    - `m_arvalid = AR_grant`.
    - On `m_arvalid && m_arready`: go to IDLE.
    - `AR_addr`, `AR_id` and `m_ar*` are held stable throughout REQ.
- **Arbiter handshake:** `AR_request` is asserted only in REQ. It drops the cycle after the interconnect handshake, which releases the arbiter's grant. `m_arvalid` is never asserted outside REQ, even if `AR_grant` is still high.
- **R skid buffer:**
  - 2 entries, FIFO order, each holding `{rdata, rresp, rlast, rid}`.
  - `m_rready` is registered, high when at least one entry is free after this cycle's activity.
  - The head entry drives `s_r*`.
- **Slot free:** on `s_rvalid && s_rready && s_rlast`, clear `busy[head rid[TID_W-1:0]]`.
- **Simultaneous events:**
  - Allocation and free in the same cycle both apply. They always target different slots.
  - A slot freed in cycle t is allocatable from t+1.
- **`rid_err`:** set when an accepted m-side beat has either of:
  - `rid[MID_W+TID_W-1:TID_W] != MASTER_ID`, or
  - `busy[rid tid] == 0`.
  
  The beat is still forwarded. The flag clears only on reset.

## Timing
- **Reset values:** FSM=IDLE, `busy=0`, skid buffer empty.
- **Outputs during reset:**
  - Low: `s_arready`, `AR_request`, `m_arvalid`, `s_rvalid`, `s_rlast`, `rid_err`.
  - Zero: `AR_addr`, `AR_id`, `m_ar*`, `s_rdata`, `s_rresp`, `outstanding`.
  - `m_rready=1` from the first cycle after reset.
- **AR latency:**
  - Accept at cycle t puts `AR_request` high at t+1.
  - `m_arvalid` follows `AR_grant` combinationally.
  - After the handshake at cycle h, `AR_request=0` and `s_arready` may be high at h+1.
  - Next accept at h+1 gives `AR_request` at h+2. This guarantees one request-low cycle between requests.
- **Pool full:** `s_arready=0` until a slot frees. The master holds `s_arvalid`.
- **R latency:**
  - A beat accepted at cycle t appears on `s_r*` at t+1.
  - Full throughput of 1 beat/cycle while `s_rready=1`.
  - Stall: `m_rready` falls the cycle after the buffer reaches 2 entries. No beat is lost.
- **Reset mid-operation:** all state is discarded immediately (async). In-flight bursts are dropped and all slots are free.

## Test plan
- **Single read:** `MASTER_ID=1`, araddr=0x0001_0040, arlen=3; `AR_grant` 2 cycles later → `AR_request` at t+1, `m_arid=2'b10`, 4 R beats forwarded in order, `outstanding` goes 1 → 0 the cycle after the last beat.
- **Pool exhaustion:** `NUM_OUTSTANDING_TRANS=2`, two reads issued, third `s_arvalid` held → `s_arready=0` until the first rlast is delivered, then third accepted with slot 0.
- **Grant delay and backpressure:** `AR_grant` delayed 5 cycles, `m_arready` low 3 cycles after grant → address stable throughout, exactly one handshake, `AR_request` low the following cycle.
- **R backpressure:** `s_rready` toggled 1,0,0,1 during an 8-beat burst with `m_rvalid` continuous → no beats dropped or duplicated, `m_rready` low while the buffer is full.
- **Errors:** beat with `m_rid=2'b01` at `MASTER_ID=1`, then a beat to a free slot → `rid_err=1`, beat still forwarded, `busy` unchanged.
- **Mid-burst reset:** `clr` pulsed low mid-burst → all outputs at reset values, `outstanding=0`, new accept gets slot 0.
